// File: rtl/fp_pkg.sv
// Shared constants and enums for the binary32 multiplier back end.
package fp_pkg;

    localparam int unsigned BIAS    = 127;
    localparam int unsigned EXP_MAX = 255;
    localparam logic [31:0] QNAN    = 32'h7FC00000;

    typedef enum logic [1:0] {
        ClsNormal = 2'b00,
        ClsZero   = 2'b01,
        ClsInf    = 2'b10,
        ClsNan    = 2'b11
    } special_e;

    typedef enum logic [2:0] {
        StIdle,
        StNorm,
        StRound,
        StPack,
        StDone
    } state_e;

endpackage

// File: rtl/fmul_round_rne.sv
// Round-to-nearest-even on a 23-bit fraction with guard and sticky bits.
module fmul_round_rne (
    input  logic [22:0] mant_i,
    input  logic        guard_i,
    input  logic        sticky_i,
    output logic [22:0] mant_o,
    output logic        carry_o,
    output logic        inexact_o
);

    logic inc;

    assign inc = guard_i & (sticky_i | mant_i[0]);
    // All-ones fraction wraps to zero; the carry bumps the exponent upstream.
    assign {carry_o, mant_o} = {1'b0, mant_i} + {23'd0, inc};
    assign inexact_o = guard_i | sticky_i;

endmodule

// File: rtl/fmul_norm_round_pack.sv
// Normalise, round (RNE) and pack a 48-bit mantissa product into binary32.
module fmul_norm_round_pack
    import fp_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic        set_ack_i,
    input  logic [47:0] product_i,
    input  logic        sign_a_i,
    input  logic        sign_b_i,
    input  logic [7:0]  exp_a_i,
    input  logic [7:0]  exp_b_i,
    input  logic [1:0]  special_i,
    output logic [31:0] result_o,
    output logic        ack_o,
    output logic        overflow_o,
    output logic        underflow_o,
    output logic        inexact_o
);

    state_e             state_q;
    logic [47:0]        prod_q;
    logic               sign_q;
    logic [7:0]         exp_a_q, exp_b_q;
    special_e           cls_q;
    logic signed [9:0]  e_q;
    logic [22:0]        mant_q;
    logic               guard_q, sticky_q, rinx_q;
    logic [31:0]        pres_q;
    logic               povf_q, punf_q, pinx_q;
    logic [31:0]        result_q;
    logic               ack_q, ovf_q, unf_q, inx_q;

    logic signed [9:0]  e_norm;
    logic [22:0]        mant_rnd;
    logic               carry_rnd, inx_rnd;
    logic [31:0]        pack_res;
    logic               pack_ovf, pack_unf, pack_inx;

    always_comb begin
        e_norm = $signed({2'b00, exp_a_q} + {2'b00, exp_b_q} - 10'(BIAS)
                         + {9'd0, prod_q[47]});
    end

    fmul_round_rne u_round (
        .mant_i    (mant_q),
        .guard_i   (guard_q),
        .sticky_i  (sticky_q),
        .mant_o    (mant_rnd),
        .carry_o   (carry_rnd),
        .inexact_o (inx_rnd)
    );

    always_comb begin
        pack_res = 32'h0;
        pack_ovf = 1'b0;
        pack_unf = 1'b0;
        pack_inx = 1'b0;
        unique case (cls_q)
            ClsZero: pack_res = {sign_q, 31'h0};
            ClsInf:  pack_res = {sign_q, 8'hFF, 23'h0};
            ClsNan:  pack_res = QNAN;
            default: begin
                pack_inx = rinx_q;
                if (e_q >= $signed(10'(EXP_MAX))) begin
                    pack_res = {sign_q, 8'hFF, 23'h0};
                    pack_ovf = 1'b1;
                    pack_inx = 1'b1;
                end else if (e_q <= 10'sd0) begin
                    pack_res = {sign_q, 31'h0};
                    pack_unf = 1'b1;
                end else begin
                    pack_res = {sign_q, e_q[7:0], mant_q};
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            prod_q   <= '0;
            sign_q   <= 1'b0;
            exp_a_q  <= '0;
            exp_b_q  <= '0;
            cls_q    <= ClsNormal;
            e_q      <= '0;
            mant_q   <= '0;
            guard_q  <= 1'b0;
            sticky_q <= 1'b0;
            rinx_q   <= 1'b0;
            pres_q   <= '0;
            povf_q   <= 1'b0;
            punf_q   <= 1'b0;
            pinx_q   <= 1'b0;
            result_q <= '0;
            ack_q    <= 1'b0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
            inx_q    <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start_i) begin
                        prod_q  <= product_i;
                        sign_q  <= sign_a_i ^ sign_b_i;
                        exp_a_q <= exp_a_i;
                        exp_b_q <= exp_b_i;
                        cls_q   <= special_e'(special_i);
                        ovf_q   <= 1'b0;
                        unf_q   <= 1'b0;
                        inx_q   <= 1'b0;
                        state_q <= StNorm;
                    end
                end
                StNorm: begin
                    e_q <= e_norm;
                    if (prod_q[47]) begin
                        mant_q   <= prod_q[46:24];
                        guard_q  <= prod_q[23];
                        sticky_q <= |prod_q[22:0];
                    end else begin
                        mant_q   <= prod_q[45:23];
                        guard_q  <= prod_q[22];
                        sticky_q <= |prod_q[21:0];
                    end
                    state_q <= StRound;
                end
                StRound: begin
                    mant_q  <= mant_rnd;
                    e_q     <= e_q + 10'(carry_rnd);
                    rinx_q  <= inx_rnd;
                    state_q <= StPack;
                end
                StPack: begin
                    pres_q  <= pack_res;
                    povf_q  <= pack_ovf;
                    punf_q  <= pack_unf;
                    pinx_q  <= pack_inx;
                    state_q <= StDone;
                end
                StDone: begin
                    // Publish on the edge after entering DONE; set_ack wins over start.
                    if (set_ack_i) begin
                        ack_q   <= 1'b0;
                        state_q <= StIdle;
                    end else begin
                        ack_q    <= 1'b1;
                        result_q <= pres_q;
                        ovf_q    <= povf_q;
                        unf_q    <= punf_q;
                        inx_q    <= pinx_q;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign result_o    = result_q;
    assign ack_o       = ack_q;
    assign overflow_o  = ovf_q;
    assign underflow_o = unf_q;
    assign inexact_o   = inx_q;

endmodule

// File: tb/tb_fmul_norm_round_pack.sv
// Directed vector bench for fmul_norm_round_pack.
module tb_fmul_norm_round_pack;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, set_ack;
    logic [47:0] product;
    logic        sign_a, sign_b;
    logic [7:0]  exp_a, exp_b;
    logic [1:0]  special;
    logic [31:0] result;
    logic        ack, overflow, underflow, inexact;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        string       name;
        logic [47:0] prod;
        logic        sa;
        logic        sb;
        logic [7:0]  ea;
        logic [7:0]  eb;
        logic [1:0]  sp;
        logic [31:0] res;
        logic        ovf;
        logic        unf;
        logic        inx;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    fmul_norm_round_pack dut (
        .clk         (clk),
        .rst         (rst),
        .start_i     (start),
        .set_ack_i   (set_ack),
        .product_i   (product),
        .sign_a_i    (sign_a),
        .sign_b_i    (sign_b),
        .exp_a_i     (exp_a),
        .exp_b_i     (exp_b),
        .special_i   (special),
        .result_o    (result),
        .ack_o       (ack),
        .overflow_o  (overflow),
        .underflow_o (underflow),
        .inexact_o   (inexact)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input vec_t v);
        product = v.prod;
        sign_a  = v.sa;
        sign_b  = v.sb;
        exp_a   = v.ea;
        exp_b   = v.eb;
        special = v.sp;
    endtask

    // Capture edge, then count edges until ack (0 = never seen within budget).
    task automatic run_op(input vec_t v, input logic hold_start, output int lat);
        drive(v);
        start = 1'b1;
        tick();
        start = hold_start;
        lat = 0;
        for (int n = 1; n <= 8; n++) begin
            tick();
            if (ack) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic check_out(input vec_t v, input int lat);
        chk({v.name, ".lat"}, 32'(lat), 32'd4);
        chk({v.name, ".res"}, result, v.res);
        chk({v.name, ".ovf"}, {31'd0, overflow}, {31'd0, v.ovf});
        chk({v.name, ".unf"}, {31'd0, underflow}, {31'd0, v.unf});
        chk({v.name, ".inx"}, {31'd0, inexact}, {31'd0, v.inx});
    endtask

    task automatic release_ack(input string name);
        set_ack = 1'b1;
        tick();
        set_ack = 1'b0;
        chk({name, ".ackclr"}, {31'd0, ack}, 32'd0);
    endtask

    vec_t v_one, v_ovf;
    int   lat;

    initial begin
        //          name        product            sa  sb  ea    eb    sp     result        o  u  i
        vecs.push_back('{"one",    48'h400000000000, 0, 0, 8'd127, 8'd127, 2'b00, 32'h3F800000, 0, 0, 0});
        vecs.push_back('{"hi_bit", 48'h900000000000, 0, 0, 8'd127, 8'd127, 2'b00, 32'h40100000, 0, 0, 0});
        vecs.push_back('{"neg_st", 48'hFFFFFE000001, 1, 0, 8'd127, 8'd127, 2'b00, 32'hC07FFFFE, 0, 0, 1});
        vecs.push_back('{"carry",  48'h7FFFFFC00000, 0, 0, 8'd127, 8'd127, 2'b00, 32'h40000000, 0, 0, 1});
        vecs.push_back('{"tie_ev", 48'h400000400000, 0, 0, 8'd127, 8'd127, 2'b00, 32'h3F800000, 0, 0, 1});
        vecs.push_back('{"ovf",    48'h400000000000, 0, 0, 8'd254, 8'd254, 2'b00, 32'h7F800000, 1, 0, 1});
        vecs.push_back('{"ovf255", 48'h400000000000, 1, 0, 8'd128, 8'd254, 2'b00, 32'hFF800000, 1, 0, 1});
        vecs.push_back('{"e254",   48'h400000000000, 0, 0, 8'd127, 8'd254, 2'b00, 32'h7F000000, 0, 0, 0});
        vecs.push_back('{"rnd255", 48'h7FFFFFC00000, 0, 0, 8'd127, 8'd254, 2'b00, 32'h7F800000, 1, 0, 1});
        vecs.push_back('{"unf",    48'h400000000000, 0, 0, 8'd32,  8'd32,  2'b00, 32'h00000000, 0, 1, 0});
        vecs.push_back('{"e1",     48'h400000000000, 0, 0, 8'd1,   8'd127, 2'b00, 32'h00800000, 0, 0, 0});
        vecs.push_back('{"e0",     48'h400000000000, 1, 1, 8'd1,   8'd126, 2'b00, 32'h00000000, 0, 1, 0});
        vecs.push_back('{"nan",    48'h400000000000, 1, 0, 8'd127, 8'd127, 2'b11, 32'h7FC00000, 0, 0, 0});
        vecs.push_back('{"zero",   48'hFFFFFFFFFFFF, 1, 0, 8'd254, 8'd254, 2'b01, 32'h80000000, 0, 0, 0});
        vecs.push_back('{"inf",    48'h400000000001, 0, 0, 8'd1,   8'd1,   2'b10, 32'h7F800000, 0, 0, 0});
        v_one = vecs[0];
        v_ovf = vecs[5];

        rst = 1'b1; start = 1'b0; set_ack = 1'b0;
        drive(v_one);
        #12;
        chk("rst.ack", {31'd0, ack}, 32'd0);
        chk("rst.res", result, 32'd0);
        chk("rst.flags", {29'd0, overflow, underflow, inexact}, 32'd0);
        rst = 1'b0;

        foreach (vecs[i]) begin
            run_op(vecs[i], 1'b0, lat);
            check_out(vecs[i], lat);
            release_ack(vecs[i].name);
        end

        // Flags clear on the capture edge of the next request.
        run_op(v_ovf, 1'b0, lat);
        chk("fclr.pre", {31'd0, overflow}, 32'd1);
        release_ack("fclr.a");
        drive(v_one);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("fclr.ovf", {31'd0, overflow}, 32'd0);
        chk("fclr.inx", {31'd0, inexact}, 32'd0);
        for (int n = 0; n < 8 && !ack; n++) tick();
        chk("fclr.res", result, 32'h3F800000);
        release_ack("fclr.b");

        // Start held throughout with changing operands; set_ack in NORM is ignored.
        drive(v_one);
        start = 1'b1;
        tick();
        drive(vecs[12]);
        set_ack = 1'b1;
        tick();
        set_ack = 1'b0;
        lat = 0;
        for (int n = 2; n <= 8; n++) begin
            tick();
            if (ack) begin
                lat = n;
                break;
            end
        end
        chk("hold.lat", 32'(lat), 32'd4);
        chk("hold.res", result, 32'h3F800000);
        // set_ack with start in DONE: back to IDLE, start dropped.
        set_ack = 1'b1;
        tick();
        set_ack = 1'b0;
        start = 1'b0;
        chk("drop.ack", {31'd0, ack}, 32'd0);
        for (int n = 0; n < 6; n++) tick();
        chk("drop.noack", {31'd0, ack}, 32'd0);

        // Reset while in ROUND aborts immediately.
        drive(vecs[1]);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        #2 rst = 1'b1;
        #1;
        chk("abort.ack", {31'd0, ack}, 32'd0);
        chk("abort.res", result, 32'd0);
        #2 rst = 1'b0;
        run_op(vecs[3], 1'b0, lat);
        check_out(vecs[3], lat);
        release_ack("post_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
